ext_bus_target_ctrl: RTL



---
 rtl/ext_tgt_pkg.sv | 27 ++
 rtl/ext_tgt_irq_ctrl.sv | 61 ++++++
 rtl/ext_bus_target_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ext_tgt_pkg.sv
// Shared types and constants for the HPS external-bus target controller.
// Build option EXT_TGT_TIMEOUT_EN (used by the top) enables the forward timeout.
package ext_tgt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FWD   = 2'd1,
        ST_LOCAL = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    localparam logic [1:0]  LOCAL_WIN    = 2'd3;

    localparam logic [3:0]  REG_STATUS   = 4'd0;
    localparam logic [3:0]  REG_MASK     = 4'd1;
    localparam logic [3:0]  REG_TMO_CNT  = 4'd2;

    localparam int          STAT_TMO_BIT = 8;
    localparam int          STAT_DEC_BIT = 9;

    localparam logic [63:0] TMO_DATA     = 64'hDEAD_BEEF_DEAD_BEEF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ext_tgt_irq_ctrl.sv
// Interrupt pending/mask registers, status sticky bits and the registered irq.
// A set arriving in the same cycle as its write-1-to-clear wins.
module ext_tgt_irq_ctrl
    import ext_tgt_pkg::*;
#(
    parameter int NUM_TGT = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_TGT-1:0] tgt_irq_i,
    input  logic [NUM_TGT-1:0] pend_clr_i,
    input  logic               tmo_set_i,
    input  logic               tmo_clr_i,
    input  logic               dec_set_i,
    input  logic               dec_clr_i,
    input  logic               mask_we_i,
    input  logic [NUM_TGT-1:0] mask_wdata_i,
    output logic [NUM_TGT-1:0] pend_o,
    output logic [NUM_TGT-1:0] mask_o,
    output logic               tmo_o,
    output logic               dec_o,
    output logic               irq_o
);

    logic [NUM_TGT-1:0] pend_q, pend_d;
    logic [NUM_TGT-1:0] mask_q, mask_d;
    logic               tmo_q, tmo_d;
    logic               dec_q, dec_d;
    logic               irq_q, irq_d;

    always_comb begin
        pend_d = (pend_q & ~pend_clr_i) | tgt_irq_i;
        tmo_d  = (tmo_q & ~tmo_clr_i) | tmo_set_i;
        dec_d  = (dec_q & ~dec_clr_i) | dec_set_i;
        mask_d = mask_we_i ? mask_wdata_i : mask_q;
        irq_d  = |(pend_q & mask_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
            mask_q <= '0;
            tmo_q  <= 1'b0;
            dec_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            tmo_q  <= tmo_d;
            dec_q  <= dec_d;
            irq_q  <= irq_d;
        end
    end

    assign pend_o = pend_q;
    assign mask_o = mask_q;
    assign tmo_o  = tmo_q;
    assign dec_o  = dec_q;
    assign irq_o  = irq_q;

endmodule

// File: rtl/ext_bus_target_ctrl.sv
// Bridge-side slave: decodes bus cycles to target windows or local registers.
// Define EXT_TGT_TIMEOUT_EN to force an error response after TIMEOUT_CYC FWD cycles.
//   state | meaning
//   IDLE  | waiting for bus_enable, request fields latched on accept
//   FWD   | target selected, waiting for its ack (or timeout)
//   LOCAL | one-cycle access to the window-3 registers
//   ACK   | acknowledge pulse with registered read_data
module ext_bus_target_ctrl
    import ext_tgt_pkg::*;
#(
    parameter int NUM_TGT     = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic                  bus_enable,
    input  logic [5:0]            address,
    input  logic [7:0]            byte_enable,
    input  logic                  rw,
    input  logic [63:0]           write_data,
    output logic [63:0]           read_data,
    output logic                  acknowledge,
    output logic                  irq,
    output logic [NUM_TGT-1:0]    tgt_sel,
    output logic [3:0]            tgt_addr,
    output logic [7:0]            tgt_be,
    output logic                  tgt_rw,
    output logic [63:0]           tgt_wdata,
    input  logic [64*NUM_TGT-1:0] tgt_rdata,
    input  logic [NUM_TGT-1:0]    tgt_ack,
    input  logic [NUM_TGT-1:0]    tgt_irq
);

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
`ifdef EXT_TGT_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [5:0]         addr_q, addr_d;
    logic [7:0]         be_q, be_d;
    logic               rw_q, rw_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [63:0]        rdata_q, rdata_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [7:0]         tmo_cnt_q, tmo_cnt_d;

    logic [NUM_TGT-1:0] sel_oh;
    logic [63:0]        fwd_rdata;
    logic               sel_ack;
    logic               tmo_fire;
    logic               tmo_set, dec_set;
    logic [63:0]        local_rdata;
    logic               status_we, mask_we;
    logic [NUM_TGT-1:0] pend_clr;
    logic [NUM_TGT-1:0] pend, mask;
    logic               tmo_st, dec_st;

    always_comb begin
        sel_oh    = '0;
        fwd_rdata = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            sel_oh[i] = (addr_q[5:4] == 2'(i));
            if (sel_oh[i]) fwd_rdata = tgt_rdata[i*64 +: 64];
        end
    end

    assign sel_ack  = |(tgt_ack & sel_oh);
    assign tmo_fire = TMO_EN && (tmr_q == '0);

    // Local register side effects happen only in the single LOCAL cycle.
    assign status_we = (state_q == ST_LOCAL) && !rw_q && (addr_q[3:0] == REG_STATUS);
    assign mask_we   = (state_q == ST_LOCAL) && !rw_q && (addr_q[3:0] == REG_MASK) && be_q[0];
    assign pend_clr  = (status_we && be_q[0]) ? wdata_q[NUM_TGT-1:0] : '0;

    always_comb begin
        local_rdata = '0;
        case (addr_q[3:0])
            REG_STATUS: begin
                local_rdata[NUM_TGT-1:0]   = pend;
                local_rdata[STAT_TMO_BIT] = tmo_st;
                local_rdata[STAT_DEC_BIT] = dec_st;
            end
            REG_MASK:    local_rdata[NUM_TGT-1:0] = mask;
            REG_TMO_CNT: local_rdata[7:0]         = tmo_cnt_q;
            default:     local_rdata = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        tmr_d     = tmr_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_set   = 1'b0;
        dec_set   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus_enable) begin
                    addr_d  = address;
                    be_d    = byte_enable;
                    rw_d    = rw;
                    wdata_d = write_data;
                    if (address[5:4] == LOCAL_WIN) begin
                        state_d = ST_LOCAL;
                    end else if (int'(address[5:4]) < NUM_TGT) begin
                        state_d = ST_FWD;
                        tmr_d   = TMR_LOAD;
                    end else begin
                        state_d = ST_ACK;
                        rdata_d = '0;
                        dec_set = 1'b1;
                    end
                end
            end
            ST_FWD: begin
                if (sel_ack) begin
                    rdata_d = rw_q ? fwd_rdata : '0;
                    state_d = ST_ACK;
                end else if (tmo_fire) begin
                    rdata_d   = TMO_DATA;
                    tmo_set   = 1'b1;
                    tmo_cnt_d = sat_inc8(tmo_cnt_q);
                    state_d   = ST_ACK;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_LOCAL: begin
                rdata_d = rw_q ? local_rdata : '0;
                state_d = ST_ACK;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            tmr_q     <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            tmr_q     <= tmr_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    ext_tgt_irq_ctrl #(
        .NUM_TGT (NUM_TGT)
    ) u_irq (
        .clk_i        (clk_clk),
        .rst_i        (reset_reset),
        .tgt_irq_i    (tgt_irq),
        .pend_clr_i   (pend_clr),
        .tmo_set_i    (tmo_set),
        .tmo_clr_i    (status_we && be_q[1] && wdata_q[STAT_TMO_BIT]),
        .dec_set_i    (dec_set),
        .dec_clr_i    (status_we && be_q[1] && wdata_q[STAT_DEC_BIT]),
        .mask_we_i    (mask_we),
        .mask_wdata_i (wdata_q[NUM_TGT-1:0]),
        .pend_o       (pend),
        .mask_o       (mask),
        .tmo_o        (tmo_st),
        .dec_o        (dec_st),
        .irq_o        (irq)
    );

    assign read_data   = rdata_q;
    assign acknowledge = (state_q == ST_ACK);
    assign tgt_sel     = (state_q == ST_FWD) ? sel_oh : '0;
    assign tgt_addr    = addr_q[3:0];
    assign tgt_be      = be_q;
    assign tgt_rw      = rw_q;
    assign tgt_wdata   = wdata_q;

endmodule
